// File: rtl/hir_mem_stream_reader_if.sv
// hir_mem_stream_reader_if: groups the control, memory read-port and output
// stream signals of hir_mem_stream_reader into one bundle.
// The optional stride input exists only when HIR_MEM_READER_STRIDE_EN is defined.
// master: the reader itself. slave: the environment around it.

interface hir_mem_stream_reader_if #(
    parameter int ADDR_WIDTH    = 10,
    parameter int ELEMENT_WIDTH = 16
);
    // control
    logic                     start;
    logic [ADDR_WIDTH-1:0]    base_addr;
    logic [ADDR_WIDTH:0]      count;
`ifdef HIR_MEM_READER_STRIDE_EN
    logic [ADDR_WIDTH-1:0]    stride;
`endif
    logic                     busy;
    logic                     done;
    // memory read port
    logic                     mem_addr_en;
    logic [ADDR_WIDTH-1:0]    mem_addr_data;
    logic                     mem_rd_en;
    logic [ELEMENT_WIDTH-1:0] mem_rd_data;
    // output stream
    logic                     out_valid;
    logic                     out_ready;
    logic [ELEMENT_WIDTH-1:0] out_data;
    logic                     out_last;

    modport master (
`ifdef HIR_MEM_READER_STRIDE_EN
        input  stride,
`endif
        input  start, base_addr, count, mem_rd_data, out_ready,
        output busy, done, mem_addr_en, mem_addr_data, mem_rd_en,
        output out_valid, out_data, out_last
    );

    modport slave (
`ifdef HIR_MEM_READER_STRIDE_EN
        output stride,
`endif
        output start, base_addr, count, mem_rd_data, out_ready,
        input  busy, done, mem_addr_en, mem_addr_data, mem_rd_en,
        input  out_valid, out_data, out_last
    );
endinterface

// File: rtl/hir_mem_stream_reader.sv
// hir_mem_stream_reader: walks a contiguous address range of a HIR memory
// read port and emits the elements as a valid/ready stream with out_last on
// the final element. Requests are only issued while the in-flight responses
// plus buffered elements leave room in the output FIFO, so the fixed read
// latency is absorbed under backpressure without ever dropping data.
// Optional build macro HIR_MEM_READER_STRIDE_EN adds a per-request address
// stride; without it the address advances by one.

module hir_mem_stream_reader_chk #(
    parameter int CNT_W      = 3,
    parameter int FIFO_DEPTH = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             i_push,
    input logic             i_pop,
    input logic [CNT_W-1:0] i_fifo_cnt
);
    // The credit rule must never let a push land on a full buffer without a pop.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(i_push && !i_pop && (i_fifo_cnt == CNT_W'(FIFO_DEPTH))));
endmodule

module hir_mem_stream_reader #(
    parameter int ADDR_WIDTH    = 10,
    parameter int ELEMENT_WIDTH = 16,
    parameter int RD_LATENCY    = 1,
    parameter int FIFO_DEPTH    = RD_LATENCY + 2
) (
    input logic                     clk,
    input logic                     rst,
    hir_mem_stream_reader_if.master bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_busy;
    logic                     r_done;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [ADDR_WIDTH-1:0]    r_step;
    logic [ADDR_WIDTH:0]      r_remaining;
    logic [ADDR_WIDTH-1:0]    w_step_start;

    logic [ELEMENT_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]    r_fifo_last;
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_fifo_cnt;

    logic [CNT_W-1:0]         w_inflight;
    logic [CNT_W-1:0]         w_credit_used;
    logic                     w_issue;
    logic                     w_issue_last;
    logic                     w_push;
    logic                     w_push_last;
    logic                     w_pop;
    logic                     w_out_valid;
    logic [ELEMENT_WIDTH-1:0] w_head_data;
    logic                     w_head_last;

`ifdef HIR_MEM_READER_STRIDE_EN
    assign w_step_start = bus.stride;
`else
    assign w_step_start = ADDR_WIDTH'(1'b1);
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1'b1);
    endfunction

    // Credit-limited issue: request only while the buffer can hold every outstanding response.
    always_comb begin
        w_credit_used = w_inflight + r_fifo_cnt;
        w_issue       = (r_state == S_RUN) && (r_remaining != '0) &&
                        (w_credit_used < CNT_W'(FIFO_DEPTH));
        w_issue_last  = w_issue && (r_remaining == REM_ONE);
    end

    generate
        if (RD_LATENCY == 0) begin : g_comb_read
            // Combinational memory: the response is captured in the issuing cycle.
            assign w_push      = w_issue;
            assign w_push_last = w_issue_last;
            assign w_inflight  = '0;
        end else begin : g_pipe_read
            logic [RD_LATENCY-1:0] r_req_vld;
            logic [RD_LATENCY-1:0] r_req_last;

            // Shift issued requests along the read latency; reset discards them.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_req_vld  <= '0;
                    r_req_last <= '0;
                end else begin
                    r_req_vld  <= (r_req_vld << 1) | RD_LATENCY'(w_issue);
                    r_req_last <= (r_req_last << 1) | RD_LATENCY'(w_issue_last);
                end
            end

            // Popcount of the in-flight tracker for the credit check.
            always_comb begin
                w_inflight = '0;
                for (int i = 0; i < RD_LATENCY; i++) begin
                    w_inflight = w_inflight + CNT_W'(r_req_vld[i]);
                end
            end

            assign w_push      = r_req_vld[RD_LATENCY-1];
            assign w_push_last = r_req_last[RD_LATENCY-1];
        end
    endgenerate

    assign w_out_valid = (r_fifo_cnt != '0);
    assign w_head_data = r_fifo_data[r_rd_ptr];
    assign w_head_last = r_fifo_last[r_rd_ptr];
    assign w_pop       = w_out_valid && bus.out_ready;

    // Next-state decode for the transfer sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.count == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_issue_last) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                if (w_pop && w_head_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register plus registered busy/done derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // Latch the transfer descriptor on start, then step address and remaining per request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr      <= '0;
            r_step      <= '0;
            r_remaining <= '0;
        end else if ((r_state == S_IDLE) && bus.start) begin
            r_addr      <= bus.base_addr;
            r_step      <= w_step_start;
            r_remaining <= bus.count;
        end else if (w_issue) begin
            r_addr      <= r_addr + r_step;
            r_remaining <= r_remaining - REM_ONE;
        end
    end

    // Output FIFO: capture read responses, release on stream handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
            end
            r_fifo_last <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fifo_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= bus.mem_rd_data;
                r_fifo_last[r_wr_ptr] <= w_push_last;
                r_wr_ptr              <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1'b1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1'b1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.mem_addr_en   = w_issue;
    assign bus.mem_rd_en     = w_issue;
    assign bus.mem_addr_data = r_addr;
    assign bus.out_valid     = w_out_valid;
    assign bus.out_data      = w_out_valid ? w_head_data : '0;
    assign bus.out_last      = w_out_valid && w_head_last;

    hir_mem_stream_reader_chk #(
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_fifo_cnt (r_fifo_cnt)
    );
endmodule

// File: tb/tb_hir_mem_stream_reader.sv
// tb_hir_mem_stream_reader: directed bench for hir_mem_stream_reader.
// Three instances: default (block RAM), ADDR_WIDTH=4 for wrap, RD_LATENCY=0.
// Memory contents everywhere are mem[a] = a + 0x100.

module tb_hir_mem_stream_reader;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

`ifdef HIR_MEM_READER_STRIDE_EN
    localparam int S6 = 3;
`else
    localparam int S6 = 1;
`endif

    hir_mem_stream_reader_if #(.ADDR_WIDTH(10), .ELEMENT_WIDTH(16)) ifA ();
    hir_mem_stream_reader_if #(.ADDR_WIDTH(4),  .ELEMENT_WIDTH(16)) ifB ();
    hir_mem_stream_reader_if #(.ADDR_WIDTH(10), .ELEMENT_WIDTH(16)) ifC ();

    hir_mem_stream_reader #(.ADDR_WIDTH(10), .ELEMENT_WIDTH(16), .RD_LATENCY(1))
        dut_a (.clk(clk), .rst(rst), .bus(ifA));
    hir_mem_stream_reader #(.ADDR_WIDTH(4), .ELEMENT_WIDTH(16), .RD_LATENCY(1))
        dut_b (.clk(clk), .rst(rst), .bus(ifB));
    hir_mem_stream_reader #(.ADDR_WIDTH(10), .ELEMENT_WIDTH(16), .RD_LATENCY(0))
        dut_c (.clk(clk), .rst(rst), .bus(ifC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: registered reads for A/B, combinational for C.
    always_ff @(posedge clk) begin
        if (ifA.mem_rd_en) ifA.mem_rd_data <= 16'h0100 + 16'(ifA.mem_addr_data);
        if (ifB.mem_rd_en) ifB.mem_rd_data <= 16'h0100 + 16'(ifB.mem_addr_data);
    end
    assign ifC.mem_rd_data = 16'h0100 + 16'(ifC.mem_addr_data);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued;
        int popped;
        int idx;
        bit held;
        bit seen_done;
        logic [15:0] held_data;
        logic        held_last;
        int          exp_addr_b [4];
        int          exp_data_b [4];
        bit          pat [6];
        exp_addr_b = '{14, 15, 0, 1};
        exp_data_b = '{16'h10E, 16'h10F, 16'h100, 16'h101};
        pat        = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b0;
        ifA.start = 1'b0; ifA.base_addr = '0; ifA.count = '0; ifA.out_ready = 1'b1;
        ifB.start = 1'b0; ifB.base_addr = '0; ifB.count = '0; ifB.out_ready = 1'b1;
        ifC.start = 1'b0; ifC.base_addr = '0; ifC.count = '0; ifC.out_ready = 1'b1;
`ifdef HIR_MEM_READER_STRIDE_EN
        ifA.stride = 10'd1; ifB.stride = 4'd1; ifC.stride = 10'(S6);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        // ---- reset state ----
        chk("rst_busy", ifA.busy, 0);
        chk("rst_done", ifA.done, 0);
        chk("rst_en", ifA.mem_addr_en, 0);
        chk("rst_valid", ifA.out_valid, 0);
        chk("rst_last", ifA.out_last, 0);
        chk("rst_addr", ifA.mem_addr_data, 0);
        chk("rst_data", ifA.out_data, 0);
        #2 rst = 1'b1;

        // ---- test 1: base 0x10, count 4, ready 1 ----
        next_cycle();
        ifA.start = 1'b1; ifA.base_addr = 10'h010; ifA.count = 11'd4; ifA.out_ready = 1'b1;
        @(negedge clk);
        chk("t1_c0_busy", ifA.busy, 0);
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            ifA.start = 1'b0;
            @(negedge clk);
            chk($sformatf("t1_c%0d_en", k), ifA.mem_addr_en, (k <= 4) ? 1 : 0);
            chk($sformatf("t1_c%0d_rden", k), ifA.mem_rd_en, (k <= 4) ? 1 : 0);
            if (k <= 4) chk($sformatf("t1_c%0d_addr", k), ifA.mem_addr_data, 32'h10 + 32'(k - 1));
            chk($sformatf("t1_c%0d_valid", k), ifA.out_valid, (k >= 3 && k <= 6) ? 1 : 0);
            if (k >= 3 && k <= 6) chk($sformatf("t1_c%0d_data", k), ifA.out_data, 32'h110 + 32'(k - 3));
            chk($sformatf("t1_c%0d_last", k), ifA.out_last, (k == 6) ? 1 : 0);
            chk($sformatf("t1_c%0d_done", k), ifA.done, (k == 7) ? 1 : 0);
            chk($sformatf("t1_c%0d_busy", k), ifA.busy, (k <= 6) ? 1 : 0);
        end

        // ---- test 2: count 8 with backpressure ----
        next_cycle();
        ifA.start = 1'b1; ifA.base_addr = 10'h020; ifA.count = 11'd8; ifA.out_ready = 1'b1;
        issued = 0; popped = 0; idx = 0; held = 1'b0; seen_done = 1'b0;
        held_data = '0; held_last = 1'b0;
        for (int cyc = 1; cyc <= 80 && !seen_done; cyc++) begin
            next_cycle();
            ifA.start = 1'b0;
            ifA.out_ready = pat[cyc % 6];
            @(negedge clk);
            chk("t2_credit", ((issued - popped) <= 3) ? 1 : 0, 1);
            if (held) begin
                chk("t2_hold_valid", ifA.out_valid, 1);
                chk("t2_hold_data", ifA.out_data, 32'(held_data));
                chk("t2_hold_last", ifA.out_last, 32'(held_last));
            end
            if (ifA.mem_addr_en) begin
                chk("t2_addr", ifA.mem_addr_data, 32'h20 + 32'(issued));
                issued++;
            end
            if (ifA.out_valid && ifA.out_ready) begin
                chk("t2_data", ifA.out_data, 32'h120 + 32'(idx));
                chk("t2_last", ifA.out_last, (idx == 7) ? 1 : 0);
                idx++;
                popped++;
            end
            held      = ifA.out_valid && !ifA.out_ready;
            held_data = ifA.out_data;
            held_last = ifA.out_last;
            if (ifA.done) seen_done = 1'b1;
        end
        chk("t2_done_seen", seen_done, 1);
        chk("t2_beats", idx, 8);
        chk("t2_issued", issued, 8);
        ifA.out_ready = 1'b1;

        // ---- test 3: address wrap, ADDR_WIDTH=4, base 14, count 4 ----
        next_cycle();
        ifB.start = 1'b1; ifB.base_addr = 4'd14; ifB.count = 5'd4; ifB.out_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            next_cycle();
            ifB.start = 1'b0;
            @(negedge clk);
            chk($sformatf("t3_c%0d_en", k), ifB.mem_addr_en, (k <= 4) ? 1 : 0);
            if (k <= 4) chk($sformatf("t3_c%0d_addr", k), ifB.mem_addr_data, 32'(exp_addr_b[k - 1]));
            chk($sformatf("t3_c%0d_valid", k), ifB.out_valid, (k >= 3 && k <= 6) ? 1 : 0);
            if (k >= 3 && k <= 6) chk($sformatf("t3_c%0d_data", k), ifB.out_data, 32'(exp_data_b[k - 3]));
            chk($sformatf("t3_c%0d_last", k), ifB.out_last, (k == 6) ? 1 : 0);
            chk($sformatf("t3_c%0d_done", k), ifB.done, (k == 7) ? 1 : 0);
        end

        // ---- test 4: count 0 ----
        next_cycle();
        ifA.start = 1'b1; ifA.base_addr = 10'h055; ifA.count = 11'd0;
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            ifA.start = 1'b0;
            @(negedge clk);
            chk($sformatf("t4_c%0d_done", k), ifA.done, (k == 1) ? 1 : 0);
            chk($sformatf("t4_c%0d_busy", k), ifA.busy, 0);
            chk($sformatf("t4_c%0d_en", k), ifA.mem_addr_en, 0);
            chk($sformatf("t4_c%0d_valid", k), ifA.out_valid, 0);
        end

        // ---- test 5: asynchronous reset mid-transfer ----
        next_cycle();
        ifA.start = 1'b1; ifA.base_addr = 10'h000; ifA.count = 11'd8; ifA.out_ready = 1'b1;
        idx = 0;
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            ifA.start = 1'b0;
            @(negedge clk);
            if (ifA.out_valid && ifA.out_ready) idx++;
        end
        chk("t5_beats_before_rst", idx, 2);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_busy", ifA.busy, 0);
        chk("t5_rst_done", ifA.done, 0);
        chk("t5_rst_en", ifA.mem_addr_en, 0);
        chk("t5_rst_rden", ifA.mem_rd_en, 0);
        chk("t5_rst_valid", ifA.out_valid, 0);
        chk("t5_rst_last", ifA.out_last, 0);
        chk("t5_rst_addr", ifA.mem_addr_data, 0);
        chk("t5_rst_data", ifA.out_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("t5_post_c%0d_done", k), ifA.done, 0);
            chk($sformatf("t5_post_c%0d_valid", k), ifA.out_valid, 0);
        end
        next_cycle();
        ifA.start = 1'b1; ifA.base_addr = 10'h000; ifA.count = 11'd2;
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            ifA.start = 1'b0;
            @(negedge clk);
            chk($sformatf("t5_c%0d_valid", k), ifA.out_valid, (k == 3 || k == 4) ? 1 : 0);
            if (k == 3 || k == 4) chk($sformatf("t5_c%0d_data", k), ifA.out_data, 32'h100 + 32'(k - 3));
            chk($sformatf("t5_c%0d_last", k), ifA.out_last, (k == 4) ? 1 : 0);
            chk($sformatf("t5_c%0d_done", k), ifA.done, (k == 5) ? 1 : 0);
        end

        // ---- test 6: RD_LATENCY=0, stride (3 when enabled, else 1), count 3 ----
        next_cycle();
        ifC.start = 1'b1; ifC.base_addr = 10'h000; ifC.count = 11'd3; ifC.out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            ifC.start = 1'b0;
            @(negedge clk);
            chk($sformatf("t6_c%0d_en", k), ifC.mem_addr_en, (k <= 3) ? 1 : 0);
            if (k <= 3) chk($sformatf("t6_c%0d_addr", k), ifC.mem_addr_data, 32'((k - 1) * S6));
            chk($sformatf("t6_c%0d_valid", k), ifC.out_valid, (k >= 2 && k <= 4) ? 1 : 0);
            if (k >= 2 && k <= 4) chk($sformatf("t6_c%0d_data", k), ifC.out_data, 32'h100 + 32'((k - 2) * S6));
            chk($sformatf("t6_c%0d_last", k), ifC.out_last, (k == 4) ? 1 : 0);
            chk($sformatf("t6_c%0d_done", k), ifC.done, (k == 5) ? 1 : 0);
            chk($sformatf("t6_c%0d_busy", k), ifC.busy, (k <= 4) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
